// File: rtl/data_producer_if.sv
// rtl/data_producer_if.sv - put-side valid/ready handshake between data_producer and its downstream FIFO
interface data_producer_if #(
    parameter int DATA_W = 32
) ();
    logic              put_valid;
    logic [DATA_W-1:0] put_data;
    logic              put_ready;

    modport master (
        output put_valid,
        output put_data,
        input  put_ready
    );

    modport slave (
        input  put_valid,
        input  put_data,
        output put_ready
    );
endinterface

// File: rtl/data_producer.sv
// rtl/data_producer.sv - arithmetic sequence generator feeding a FIFO over a valid/ready put handshake
// Optional inter-word throttling (gap port, GAP state) is built when PRODUCER_THROTTLE_EN is defined.
module data_producer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] start_val,
    input  logic [DATA_W-1:0] step,
    input  logic [CNT_W-1:0]  count,
`ifdef PRODUCER_THROTTLE_EN
    input  logic [3:0]        gap,
`endif
    data_producer_if.master   put,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
`ifdef PRODUCER_THROTTLE_EN
        , GAP = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] step_r;
    logic [CNT_W-1:0]  remaining;
`ifdef PRODUCER_THROTTLE_EN
    logic [3:0]        gap_r;
    logic [3:0]        gap_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            put.put_valid <= 1'b0;
            put.put_data  <= '0;
            step_r        <= '0;
            remaining     <= '0;
            sent_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef PRODUCER_THROTTLE_EN
            gap_r         <= 4'd0;
            gap_cnt       <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sent_cnt <= '0;
                        if (count != '0) begin
                            step_r        <= step;
                            put.put_data  <= start_val;
                            remaining     <= count;
                            put.put_valid <= 1'b1;
                            busy          <= 1'b1;
                            state         <= RUN;
`ifdef PRODUCER_THROTTLE_EN
                            gap_r         <= gap;
`endif
                        end else begin
                            // empty sequence: report completion without ever offering a word
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                RUN: begin
                    if (put.put_ready) begin
                        put.put_data <= put.put_data + step_r;
                        remaining    <= remaining - CNT_ONE;
                        sent_cnt     <= sent_cnt + CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            put.put_valid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end
`ifdef PRODUCER_THROTTLE_EN
                        else if (gap_r != 4'd0) begin
                            put.put_valid <= 1'b0;
                            gap_cnt       <= gap_r;
                            state         <= GAP;
                        end
`endif
                    end
                end

`ifdef PRODUCER_THROTTLE_EN
                // idle for exactly gap_r cycles with valid low before offering the next word
                GAP: begin
                    if (gap_cnt == 4'd1) begin
                        put.put_valid <= 1'b1;
                        state         <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_producer.sv
// tb/tb_data_producer.sv - table-driven directed bench for data_producer
module tb_data_producer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_val;
    logic [31:0] step;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;
`ifdef PRODUCER_THROTTLE_EN
    logic [3:0]  gap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    data_producer_if #(.DATA_W(32)) pif ();

    data_producer #(.DATA_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_val (start_val),
        .step      (step),
        .count     (count),
`ifdef PRODUCER_THROTTLE_EN
        .gap       (gap),
`endif
        .put       (pif),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      sv;
        logic [31:0]      st;
        logic [15:0]      cnt;
        logic [3:0]       rdy;
        logic [3:0][31:0] w;
        int               cyc;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   idx;
        int   cyc;
        int   dones;
        logic accepted;
        @(posedge clk); #1;
        start = 1'b1; start_val = v.sv; step = v.st; count = v.cnt;
        pif.put_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        dones = done ? 1 : 0;
        if (v.cnt != 16'd0) begin
            chk("first_word_latency", {63'd0, pif.put_valid}, 64'd1);
            chk("first_word_data", {32'd0, pif.put_data}, {32'd0, v.w[0]});
            chk("busy_after_start", {63'd0, busy}, 64'd1);
        end else begin
            chk("count0_done", {63'd0, done}, 64'd1);
            chk("count0_no_valid", {63'd0, pif.put_valid}, 64'd0);
        end
        idx = 0;
        cyc = 0;
        while (dones == 0 && cyc < 64) begin
            pif.put_ready = v.rdy[cyc % 4];
            #1;
            if (pif.put_valid) begin
                chk("no_extra_word", {63'd0, (idx < int'(v.cnt))}, 64'd1);
                if (idx < int'(v.cnt))
                    chk("word_data", {32'd0, pif.put_data}, {32'd0, v.w[idx]});
            end
            accepted = pif.put_valid && pif.put_ready;
            @(posedge clk); #1;
            if (accepted) idx++;
            if (done) dones++;
            cyc++;
        end
        pif.put_ready = 1'b0;
        chk("done_seen", 64'(dones), 64'd1);
        chk("done_cycle", 64'(cyc), 64'(v.cyc));
        chk("words_accepted", 64'(idx), 64'(v.cnt));
        chk("sent_cnt_final", {48'd0, sent_cnt}, {48'd0, v.cnt});
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("valid_at_done", {63'd0, pif.put_valid}, 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("sent_cnt_hold", {48'd0, sent_cnt}, {48'd0, v.cnt});
    endtask

    initial begin
        vecs[0] = '{32'd5, 32'd3, 16'd4, 4'b1111, {32'd14, 32'd11, 32'd8, 32'd5}, 4};
        vecs[1] = '{32'd5, 32'd3, 16'd4, 4'b1001, {32'd14, 32'd11, 32'd8, 32'd5}, 8};
        vecs[2] = '{32'hFFFF_FFFE, 32'd1, 16'd3, 4'b1111,
                    {32'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE}, 3};
        vecs[3] = '{32'd100, 32'hFFFF_FFFF, 16'd2, 4'b0101, {32'd0, 32'd0, 32'd99, 32'd100}, 3};
        vecs[4] = '{32'd7, 32'd7, 16'd0, 4'b1111, {32'd0, 32'd0, 32'd0, 32'd0}, 0};

        rst = 1'b1; start = 1'b0; start_val = '0; step = '0; count = '0;
        pif.put_ready = 1'b0;
`ifdef PRODUCER_THROTTLE_EN
        gap = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, pif.put_valid}, 64'd0);
        chk("rst_data", {32'd0, pif.put_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sent_cnt", {48'd0, sent_cnt}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // start while busy is ignored and not queued
        @(posedge clk); #1;
        start = 1'b1; start_val = 32'd10; step = 32'd10; count = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; start_val = 32'd999; step = 32'd1; count = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_ignored", {32'd0, pif.put_data}, 64'd10);
        pif.put_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("busy_seq_valid", {63'd0, pif.put_valid}, 64'd1);
            chk("busy_seq_word", {32'd0, pif.put_data}, 64'(32'd10 * (k + 1)));
            @(posedge clk); #1;
        end
        pif.put_ready = 1'b0;
        chk("busy_seq_done", {63'd0, done}, 64'd1);
        chk("busy_seq_sent", {48'd0, sent_cnt}, 64'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_queued_start", {63'd0, pif.put_valid | busy}, 64'd0);
        end

        // reset after two of six words accepted
        start = 1'b1; start_val = 32'd0; step = 32'd1; count = 16'd6;
        @(posedge clk); #1;
        start = 1'b0;
        pif.put_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_sent", {48'd0, sent_cnt}, 64'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pif.put_ready = 1'b0;
        chk("midrst_valid", {63'd0, pif.put_valid}, 64'd0);
        chk("midrst_sent", {48'd0, sent_cnt}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", {63'd0, done | pif.put_valid}, 64'd0);
        end
        run_vec(vecs[0]);

`ifdef PRODUCER_THROTTLE_EN
        begin
            int acc_cyc [3];
            int n_acc;
            logic accepted;
            @(posedge clk); #1;
            start = 1'b1; start_val = 32'd1; step = 32'd1; count = 16'd3; gap = 4'd2;
            @(posedge clk); #1;
            start = 1'b0;
            pif.put_ready = 1'b1;
            n_acc = 0;
            for (int k = 1; k <= 12; k++) begin
                accepted = pif.put_valid && pif.put_ready;
                @(posedge clk); #1;
                if (accepted && n_acc < 3) begin
                    acc_cyc[n_acc] = k;
                    n_acc++;
                end
            end
            pif.put_ready = 1'b0;
            gap = 4'd0;
            chk("gap_accepts", 64'(n_acc), 64'd3);
            if (n_acc == 3) begin
                chk("gap_acc0", 64'(acc_cyc[0]), 64'd1);
                chk("gap_acc1", 64'(acc_cyc[1]), 64'd4);
                chk("gap_acc2", 64'(acc_cyc[2]), 64'd7);
            end
            chk("gap_sent", {48'd0, sent_cnt}, 64'd3);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_producer.md
# data_producer

Synthesizable upstream stage for the integer data path. It generates a programmed arithmetic sequence of words and pushes them into the downstream FIFO over a valid/ready put handshake. The FIFO's consumer drains these words and displays them. The block replaces testbench-only producers, so the same sequence source works in simulation and on the FPGA.

## Interface
Parameters:
- DATA_W, 32, width of data words and step
- CNT_W, 16, width of the transfer count and sent counter

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE
- start_val  input  DATA_W  first word of the sequence; sampled with start
- step  input  DATA_W  increment between words; sampled with start
- count  input  CNT_W  number of words to send; sampled with start
- put_valid  output  1  put_data holds a word for the FIFO
- put_data  output  DATA_W  current word
- put_ready  input  1  FIFO can accept (not full)
- busy  output  1  high in RUN and GAP
- done  output  1  one-cycle pulse when a sequence completes
- sent_cnt  output  CNT_W  words accepted in the current or last sequence

Reset and synchronicity are fixed: one clock, clk; reset rst is synchronous and active-high.

## Operation
- States: IDLE, RUN, GAP (only with the macro), DONE.
- **IDLE.** When start=1 and count!=0: latch step, load put_data=start_val and remaining=count, clear sent_cnt, then go to RUN. When start=1 and count==0: clear sent_cnt and go to DONE. Otherwise hold.
- **RUN.** put_valid=1. A transfer occurs when put_valid && put_ready.
  - On a transfer: put_data <= put_data + step, modulo 2^DATA_W; overflow wraps silently. remaining decrements and sent_cnt increments.
  - On the transfer where remaining==1, go to DONE.
- **DONE.** done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE; no queuing.
- put_data and put_valid stay stable while put_valid=1 and put_ready=0. The block never drops or retracts a word.
- sent_cnt holds its final value in IDLE until the next start.
- **Reset values.** put_valid=0, put_data=0, busy=0, done=0, sent_cnt=0, state=IDLE.
- **Reset mid-sequence.** The state returns to IDLE the next edge. Any unaccepted word is abandoned and no done pulse is generated.

## Timing
- start sampled at edge N gives put_valid=1 with put_data=start_val after edge N. This is one cycle of latency.
- With put_ready held at 1, the block sends one word per cycle. The last word is accepted at edge N+count, and done is high in the cycle after that edge.
- For count==0, done is high in the cycle after edge N and put_valid never asserts.
- put_ready low stalls the sequence with no extra penalty. Acceptance resumes on the first edge where ready=1.
- The earliest new start is accepted in the cycle after done, once the block is back in IDLE.
- busy is high from the edge after start until the final transfer edge.

## Configuration
- Macro: PRODUCER_THROTTLE_EN.
- **Defined.** Adds input port gap (width 4), sampled with start.
  - After each transfer that is not the last, the block enters GAP with put_valid=0 for gap cycles, then returns to RUN.
  - gap==0 behaves identically to the undefined build.
- **Undefined.** The gap port and GAP state do not exist, and transfers can occur back to back.

## Test plan
- Reset, then start_val=5, step=3, count=4, put_ready=1 -> put_data 5,8,11,14 on four consecutive cycles; done pulses once; sent_cnt=4; busy low afterward.
- Same sequence with put_ready toggled 1,0,0,1,... -> the same four words in order; each word is held stable while ready=0; no duplicates.
- start_val=32'hFFFFFFFE, step=1, count=3 -> words FFFFFFFE, FFFFFFFF, 00000000.
- count=0 with start -> done one cycle later; put_valid never high; sent_cnt=0. A second start pulse while busy is ignored.
- Assert rst after 2 of 6 words are accepted -> put_valid=0, sent_cnt=0, no done; a new start works normally.
- With PRODUCER_THROTTLE_EN and gap=2, count=3, ready=1 -> transfers on cycles 1, 4 and 7 after start.
